// File: rtl/tx_framer_pkg.sv
// Shared constants, state encoding and stuffing helpers for the TX framer
// and the matching link receiver.
package tx_framer_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h7E;
    localparam logic [7:0] ESC_BYTE = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_SOF,
        SOF,
        CHAN,
        DATA,
        DATA_ESC,
        LOAD,
        CSUM,
        CSUM_ESC,
        EOF
    } state_t;

    // True when a payload/checksum byte collides with a framing byte.
    function automatic logic needs_stuff(input logic [7:0] b);
        return (b == SOF_BYTE) || (b == ESC_BYTE);
    endfunction

    // First wire byte for a stuffable byte: the escape marker or the byte itself.
    function automatic logic [7:0] first_byte(input logic [7:0] b);
        return needs_stuff(b) ? ESC_BYTE : b;
    endfunction

endpackage

// File: rtl/tx_framer_if.sv
// FIFO read port plus valid/ready byte stream between the framer (master)
// and its environment (slave).
interface tx_framer_if;

    logic       i_fifo_empty;
    logic       o_pop;
    logic [7:0] i_fifo_data;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       i_tready;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_data,
        input  i_tready,
        output o_pop,
        output o_tdata,
        output o_tvalid
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_data,
        output i_tready,
        input  o_pop,
        input  o_tdata,
        input  o_tvalid
    );

endinterface

// File: rtl/tx_framer.sv
// HDLC-style framer: pops payload bytes from tx_fifo and emits
// SOF, channel ID, stuffed payload, stuffed XOR checksum, EOF.
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64,
    parameter logic [7:0]  CHAN_ID = 8'h01
) (
    input  logic          i_clk,
    input  logic          i_rst,
    tx_framer_if.master   link,
    output logic          o_busy,
    output logic          o_frame_done
);

    localparam int unsigned   CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    generate
        if (CHAN_ID == SOF_BYTE || CHAN_ID == ESC_BYTE) begin : g_bad_chan
            $error("tx_framer: CHAN_ID must not be a framing byte (0x7E/0x7D)");
        end
        if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_len
            $error("tx_framer: MAX_LEN must be in 1..255");
        end
    endgenerate

    state_t        state;
    logic [7:0]    hold;
    logic [7:0]    csum;
    logic [CW-1:0] count;

    logic xfer;
    logic more;
    logic pop_next;

    // Handshake decode; pops must coincide with the transfer that frees the hold register.
    always_comb begin
        xfer         = link.o_tvalid & link.i_tready;
        more         = (count < MAX_CNT) & ~link.i_fifo_empty;
        pop_next     = xfer & more &
                       (((state == DATA) & ~needs_stuff(hold)) | (state == DATA_ESC));
        link.o_pop   = ~i_rst & (((state == IDLE) & ~link.i_fifo_empty) | pop_next);
        o_busy       = (state != IDLE);
        o_frame_done = (state == EOF) & xfer;
    end

    // Frame sequencer; o_tdata/o_tvalid are loaded on entry to each state and only
    // change on a transfer, so they hold steady while the sink stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            hold        <= '0;
            csum        <= '0;
            count       <= '0;
            link.o_tdata  <= '0;
            link.o_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!link.i_fifo_empty) begin
                        state <= LOAD_SOF;
                    end
                end
                LOAD_SOF: begin
                    hold          <= link.i_fifo_data;
                    count         <= CW'(1);
                    csum          <= CHAN_ID ^ link.i_fifo_data;
                    link.o_tdata  <= SOF_BYTE;
                    link.o_tvalid <= 1'b1;
                    state         <= SOF;
                end
                SOF: begin
                    if (xfer) begin
                        link.o_tdata <= CHAN_ID;
                        state        <= CHAN;
                    end
                end
                CHAN: begin
                    if (xfer) begin
                        link.o_tdata <= first_byte(hold);
                        state        <= DATA;
                    end
                end
                DATA, DATA_ESC: begin
                    if (xfer) begin
                        if (state == DATA && needs_stuff(hold)) begin
                            link.o_tdata <= hold ^ ESC_XOR;
                            state        <= DATA_ESC;
                        end else if (more) begin
                            link.o_tvalid <= 1'b0;
                            state         <= LOAD;
                        end else begin
                            link.o_tdata <= first_byte(csum);
                            state        <= CSUM;
                        end
                    end
                end
                LOAD: begin
                    hold          <= link.i_fifo_data;
                    count         <= count + CW'(1);
                    csum          <= csum ^ link.i_fifo_data;
                    link.o_tdata  <= first_byte(link.i_fifo_data);
                    link.o_tvalid <= 1'b1;
                    state         <= DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        if (needs_stuff(csum)) begin
                            link.o_tdata <= csum ^ ESC_XOR;
                            state        <= CSUM_ESC;
                        end else begin
                            link.o_tdata <= SOF_BYTE;
                            state        <= EOF;
                        end
                    end
                end
                CSUM_ESC: begin
                    if (xfer) begin
                        link.o_tdata <= SOF_BYTE;
                        state        <= EOF;
                    end
                end
                EOF: begin
                    if (xfer) begin
                        link.o_tvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    link.o_tvalid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: FIFO model, stream capture, deframing and checks.
module tb_tx_framer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic frame_done;

    tx_framer_if link();

    tx_framer #(.MAX_LEN(64), .CHAN_ID(8'h01)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .link         (link),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic [7:0] stage[$];
    logic [7:0] outq[$];
    logic [7:0] inq[$];
    logic [7:0] rxq[$];
    int         flens[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   n_pop = 0;
    bit   pop_s = 1'b0;
    bit   rnd_ready = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        stage.push_back(b);
    endtask

    // One clock: update FIFO/ready after the edge, observe at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (pop_s) begin
            if (fq.size() > 0) link.i_fifo_data = fq.pop_front();
            pop_s = 1'b0;
        end
        while (stage.size() > 0) fq.push_back(stage.pop_front());
        link.i_fifo_empty = (fq.size() == 0);
        link.i_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold", {link.o_tvalid, link.o_tdata}, {1'b1, prev_data});
            if (link.o_tvalid && link.i_tready) outq.push_back(link.o_tdata);
            prev_stall = link.o_tvalid && !link.i_tready;
            prev_data  = link.o_tdata;
            if (link.o_pop) begin
                check("pop_ne", link.i_fifo_empty, 0);
                n_pop++;
                pop_s = 1'b1;
            end
            if (frame_done) n_done++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(fq.size() == 0 && stage.size() == 0 && link.i_fifo_empty && !busy) && n < budget);
        check("idle_to", 32'(n < budget), 1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] e[$]);
        check({tag, "_len"}, outq.size(), e.size());
        for (int i = 0; i < e.size() && i < outq.size(); i++) check(tag, outq[i], e[i]);
    endtask

    // Independent receiver: split the captured stream into frames and unstuff.
    task automatic deframe();
        int i;
        logic [7:0] b;
        logic [7:0] cs;
        logic [7:0] body[$];
        rxq.delete();
        flens.delete();
        i = 0;
        while (i < outq.size()) begin
            check("df_sof", outq[i], 8'h7E);
            i++;
            if (i >= outq.size()) break;
            check("df_chan", outq[i], 8'h01);
            i++;
            body.delete();
            while (i < outq.size() && outq[i] != 8'h7E) begin
                b = outq[i];
                i++;
                if (b == 8'h7D && i < outq.size()) begin
                    b = outq[i] ^ 8'h20;
                    i++;
                end
                body.push_back(b);
            end
            check("df_eof", 32'(i < outq.size()), 1);
            i++;
            if (body.size() < 2) begin
                check("df_short", body.size(), 2);
                continue;
            end
            cs = 8'h01;
            for (int k = 0; k < body.size() - 1; k++) begin
                cs ^= body[k];
                rxq.push_back(body[k]);
            end
            check("df_csum", body[body.size() - 1], cs);
            flens.push_back(body.size() - 1);
        end
    endtask

    task automatic start_test();
        outq.delete();
        inq.delete();
        n_done = 0;
        n_pop  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        int n;

        link.i_fifo_empty = 1'b1;
        link.i_fifo_data  = 8'h00;
        link.i_tready     = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_tvalid", link.o_tvalid, 0);
        check("rst_tdata", link.o_tdata, 8'h00);
        check("rst_pop", link.o_pop, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        repeat (3) cycle();
        rst = 1'b0;

        // Single plain byte
        start_test();
        push(8'h11);
        wait_idle(50);
        e = {8'h7E, 8'h01, 8'h11, 8'h10, 8'h7E};
        check_stream("t1", e);
        check("t1_done", n_done, 1);
        check("t1_busy", busy, 0);

        // Payload equal to SOF gets escaped
        start_test();
        push(8'h7E);
        wait_idle(50);
        e = {8'h7E, 8'h01, 8'h7D, 8'h5E, 8'h7F, 8'h7E};
        check_stream("t2", e);

        // Checksum equal to ESC gets escaped
        start_test();
        push(8'h7C);
        wait_idle(50);
        e = {8'h7E, 8'h01, 8'h7C, 8'h7D, 8'h5D, 8'h7E};
        check_stream("t3", e);

        // 66 bytes split at MAX_LEN
        start_test();
        for (int k = 1; k <= 66; k++) begin
            inq.push_back(8'(k));
            push(8'(k));
        end
        wait_idle(1000);
        deframe();
        check("t4_frames", flens.size(), 2);
        if (flens.size() == 2) begin
            check("t4_len0", flens[0], 64);
            check("t4_len1", flens[1], 2);
        end
        check("t4_rxlen", rxq.size(), 66);
        for (int k = 0; k < rxq.size() && k < 66; k++) check("t4_pay", rxq[k], inq[k]);
        check("t4_done", n_done, 2);
        check("t4_pops", n_pop, 66);

        // Random backpressure, staggered arrivals, stuffable bytes included
        start_test();
        rnd_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (k == 3 || k == 15) b = 8'h7E;
            if (k == 7 || k == 20) b = 8'h7D;
            inq.push_back(b);
        end
        for (int k = 0; k < 12; k++) push(inq[k]);
        repeat (30) cycle();
        for (int k = 12; k < 24; k++) push(inq[k]);
        wait_idle(2000);
        rnd_ready = 1'b0;
        deframe();
        check("t5_rxlen", rxq.size(), 24);
        for (int k = 0; k < rxq.size() && k < 24; k++) check("t5_pay", rxq[k], inq[k]);
        check("t5_done", n_done, flens.size());
        check("t5_pops", n_pop, 24);

        // Reset in the middle of a 10-byte frame
        start_test();
        for (int k = 0; k < 10; k++) push(8'h20 + 8'(k));
        n = 0;
        while (!(link.o_tvalid && outq.size() >= 3) && n < 100) begin
            cycle();
            n++;
        end
        check("t6_reach", 32'(n < 100), 1);
        rst = 1'b1;
        #1;
        check("t6_tvalid", link.o_tvalid, 0);
        check("t6_pop", link.o_pop, 0);
        check("t6_busy", busy, 0);
        fq.delete();
        stage.delete();
        link.i_fifo_empty = 1'b1;
        pop_s = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        start_test();
        push(8'hA1);
        push(8'h7D);
        push(8'h05);
        wait_idle(100);
        e = {8'h7E, 8'h01, 8'hA1, 8'h7D, 8'h5D, 8'h05, 8'hD8, 8'h7E};
        check_stream("t6", e);
        check("t6_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
